// File: rtl/jno_branch_sequencer.sv
// Multi-cycle fetch/decode/execute controller resolving JMP and JNO into the PC-mux select.
// Also produces the IR/PC/regfile strobes, a post-branch flush window, halt and a retired-instruction count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for run
//   S_FETCH  | waiting for mem_ready; loads IR when it arrives
//   S_DECODE | samples opcode/ovf_flag, picks EXEC, BRANCH or HALT
//   S_EXEC   | PC+1 and register write (write suppressed for not-taken JNO)
//   S_BRANCH | PC loads the latched branch/jump target
//   S_FLUSH  | squashes the in-flight fetch for FLUSH_CYC cycles
//   S_HALT   | stopped until reset
module jno_branch_sequencer #(
   parameter int                 OPC_W     = 4,
   parameter int                 CNT_W     = 16,
   parameter logic [OPC_W-1:0]   JNO_OPC   = 4'b1100,
   parameter logic [OPC_W-1:0]   JMP_OPC   = 4'b1101,
   parameter logic [OPC_W-1:0]   HALT_OPC  = 4'b1111,
   parameter int                 FLUSH_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [OPC_W-1:0] opcode,
   input  logic             ovf_flag,
   output logic [1:0]       pc_sel,
   output logic             pc_load,
   output logic             ir_load,
   output logic             reg_we,
   output logic             flush,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_FLUSH, S_HALT
   } state_t;

   localparam logic [1:0] SEL_INC = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_JMP = 2'b10;
   // Marks a not-taken JNO for EXEC; pc_sel is forced to 00 there, so 11 never leaves the block.
   localparam logic [1:0] SEL_NT  = 2'b11;
   localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

   state_t     state, state_nxt;
   logic [1:0] sel_q, sel_nxt;
   logic [3:0] flush_cnt, flush_cnt_nxt;
   logic       cnt_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         sel_q     <= SEL_INC;
         flush_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         sel_q     <= sel_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel_q;
      flush_cnt_nxt = flush_cnt;
      case (state)
         S_IDLE:   if (run) state_nxt = S_FETCH;
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            if (opcode == HALT_OPC) begin
               state_nxt = S_HALT;
            end else if (opcode == JMP_OPC) begin
               sel_nxt   = SEL_JMP;
               state_nxt = S_BRANCH;
            end else if (opcode == JNO_OPC && !ovf_flag) begin
               sel_nxt   = SEL_BR;
               state_nxt = S_BRANCH;
            end else if (opcode == JNO_OPC) begin
               sel_nxt   = SEL_NT;
               state_nxt = S_EXEC;
            end else begin
               sel_nxt   = SEL_INC;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC:   state_nxt = S_FETCH;
         S_BRANCH: begin
            flush_cnt_nxt = FLUSH_LD;
            state_nxt     = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_cnt <= 4'd1) begin
               flush_cnt_nxt = 4'd0;
               state_nxt     = S_FETCH;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pc_sel  = SEL_INC;
      pc_load = 1'b0;
      ir_load = 1'b0;
      reg_we  = 1'b0;
      flush   = 1'b0;
      busy    = 1'b0;
      halted  = 1'b0;
      case (state)
         S_FETCH: begin
            busy    = 1'b1;
            ir_load = mem_ready;
         end
         S_DECODE: busy = 1'b1;
         S_EXEC: begin
            busy    = 1'b1;
            pc_load = 1'b1;
            reg_we  = (sel_q != SEL_NT);
         end
         S_BRANCH: begin
            busy    = 1'b1;
            pc_load = 1'b1;
            pc_sel  = sel_q;
         end
         S_FLUSH: begin
            busy  = 1'b1;
            flush = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   // Every DECODE exit except HALT retires an instruction.
   assign cnt_inc = (state == S_DECODE) && (opcode != HALT_OPC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count <= '0;
      end else if (cnt_inc && (instr_count != {CNT_W{1'b1}})) begin
         instr_count <= instr_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_jno_branch_sequencer.sv
// Randomized scoreboard bench: the driver derives per-cycle expected outputs from instruction-level
// timing rules and queues them; a negedge monitor pops and compares.
module tb_jno_branch_sequencer;
   localparam int CNT_W     = 4;
   localparam int FLUSH_CYC = 3;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
   localparam logic [3:0] JNO = 4'b1100;
   localparam logic [3:0] JMP = 4'b1101;
   localparam logic [3:0] HLT = 4'b1111;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             run = 1'b0;
   logic             mem_ready = 1'b0;
   logic [3:0]       opcode = 4'd0;
   logic             ovf_flag = 1'b0;
   logic [1:0]       pc_sel;
   logic             pc_load, ir_load, reg_we, flush, busy, halted;
   logic [CNT_W-1:0] instr_count;

   jno_branch_sequencer #(
      .OPC_W(4), .CNT_W(CNT_W), .JNO_OPC(JNO), .JMP_OPC(JMP), .HALT_OPC(HLT),
      .FLUSH_CYC(FLUSH_CYC)
   ) u_dut (
      .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .opcode(opcode),
      .ovf_flag(ovf_flag), .pc_sel(pc_sel), .pc_load(pc_load), .ir_load(ir_load),
      .reg_we(reg_we), .flush(flush), .busy(busy), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   logic [8+CNT_W-1:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cnt = 0;

   wire [8+CNT_W-1:0] got = {pc_sel, pc_load, ir_load, reg_we, flush, busy, halted, instr_count};

   initial begin : monitor
      logic [8+CNT_W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL outputs t=%0t {sel,pl,il,we,fl,busy,halt,cnt} got=%b_%b%b%b%b%b%b_%0d required=%b_%b%b%b%b%b%b_%0d",
                        $time, got[CNT_W+7:CNT_W+6], got[CNT_W+5], got[CNT_W+4], got[CNT_W+3],
                        got[CNT_W+2], got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
                        e[CNT_W+7:CNT_W+6], e[CNT_W+5], e[CNT_W+4], e[CNT_W+3],
                        e[CNT_W+2], e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
            end
         end
      end
   end

   function automatic logic [8+CNT_W-1:0] ev(input logic [1:0] s, input logic pl, input logic il,
                                             input logic we, input logic fl, input logic bz,
                                             input logic hl);
      return {s, pl, il, we, fl, bz, hl, CNT_W'(cnt)};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic [3:0] alu_op();
      int v = $urandom_range(0, 12);
      return (v == 12) ? 4'd14 : 4'(v);
   endfunction

   task automatic step(input logic r, input logic rn, input logic mr, input logic [3:0] op,
                       input logic ov, input logic [8+CNT_W-1:0] e, input bit rst_mid);
      @(posedge clk);
      #1;
      rst = r; run = rn; mem_ready = mr; opcode = op; ovf_flag = ov;
      exp_q.push_back(e);
      if (rst_mid) begin
         #1 rst = 1'b1;
      end
   endtask

   task automatic do_reset();
      cnt = 0;
      step(1'b1, rb(), rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b0);
      step(1'b1, rb(), rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b0);
      step(1'b0, 1'b0, rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b0);
   endtask

   task automatic idle_start();
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b0);
      step(1'b0, 1'b1, rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b0);
   endtask

   // One instruction from FETCH entry to the cycle before the next FETCH; HALT ends in HALT.
   task automatic instr(input logic [3:0] op, input logic ov, input int waits, input bit mid_rst);
      logic taken;
      repeat (waits) step(1'b0, rb(), 1'b0, rop(), rb(), ev(2'b00, 0, 0, 0, 0, 1, 0), 1'b0);
      step(1'b0, rb(), 1'b1, rop(), rb(), ev(2'b00, 0, 1, 0, 0, 1, 0), 1'b0);
      step(1'b0, rb(), rb(), op, ov, ev(2'b00, 0, 0, 0, 0, 1, 0), 1'b0);
      if (op == HLT) begin
         repeat (4) step(1'b0, 1'b1, rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 1), 1'b0);
         repeat (2) step(1'b0, rb(), rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 1), 1'b0);
         return;
      end
      if (cnt < CNT_MAX) cnt++;
      taken = (op == JMP) || (op == JNO && !ov);
      if (taken) begin
         step(1'b0, rb(), rb(), rop(), rb(), ev((op == JMP) ? 2'b10 : 2'b01, 1, 0, 0, 0, 1, 0), 1'b0);
         repeat (FLUSH_CYC) step(1'b0, rb(), rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 1, 1, 0), 1'b0);
      end else if (mid_rst) begin
         cnt = 0;
         step(1'b0, rb(), rb(), rop(), rb(), ev(2'b00, 0, 0, 0, 0, 0, 0), 1'b1);
      end else begin
         step(1'b0, rb(), rb(), rop(), rb(), ev(2'b00, 1, 0, !(op == JNO && ov), 0, 1, 0), 1'b0);
      end
   endtask

   initial begin : driver
      int k;
      do_reset();
      idle_start();
      instr(4'b0001, 1'b0, 0, 1'b0);
      instr(JNO, 1'b0, 0, 1'b0);
      instr(JNO, 1'b1, 0, 1'b0);
      instr(JMP, 1'b0, 0, 1'b0);
      instr(4'b0010, 1'b0, 5, 1'b0);
      repeat (14) instr(alu_op(), rb(), 0, 1'b0);
      instr(HLT, rb(), 0, 1'b0);
      do_reset();
      idle_start();
      instr(4'b0011, 1'b0, 0, 1'b0);
      instr(4'b0100, 1'b0, 0, 1'b1);
      do_reset();
      idle_start();
      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 99);
         if (k < 4) begin
            instr(HLT, rb(), $urandom_range(0, 2), 1'b0);
            do_reset();
            idle_start();
         end else if (k < 7) begin
            instr(alu_op(), 1'b0, 0, 1'b1);
            do_reset();
            idle_start();
         end else if (k < 30) begin
            instr(JNO, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b0);
         end else if (k < 45) begin
            instr(JMP, rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b0);
         end else begin
            instr(alu_op(), rb(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b0);
         end
      end
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/jno_branch_sequencer.md
Name: jno_branch_sequencer

Overview:
- Multi-cycle control FSM for the final-paper processor.
- Sequences fetch/decode/execute and resolves JMP and JNO (jump if no overflow) into the 2-bit PC-select that drives the PC mux.
- Generates IR/PC/register-file load strobes, a pipeline flush after taken branches, a halt indication and a retired-instruction counter.

Parameters:
- OPC_W, 4, opcode width.
- CNT_W, 16, retired-instruction counter width.
- JNO_OPC, 4'b1100, opcode of jump-if-no-overflow.
- JMP_OPC, 4'b1101, opcode of unconditional jump.
- HALT_OPC, 4'b1111, opcode of halt.
- FLUSH_CYC, 1, flush cycles after a taken branch (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  start request; sampled only in IDLE.
- mem_ready  input  1  instruction memory data valid.
- opcode  input  OPC_W  opcode field of the instruction register.
- ovf_flag  input  1  ALU overflow flag.
- pc_sel  output  2  PC mux select: 00 PC+1, 01 branch target, 10 jump target; 11 is never driven.
- pc_load  output  1  PC write enable.
- ir_load  output  1  instruction register write enable.
- reg_we  output  1  register-file write enable.
- flush  output  1  squash in-flight fetch.
- busy  output  1  high in any state other than IDLE or HALT.
- halted  output  1  high in HALT.
- instr_count  output  CNT_W  retired instructions, saturating.

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high.
- rst asserted, at any time including mid-instruction:
  - state goes to IDLE immediately.
  - All outputs go to 0, including pc_sel=00 and instr_count=0.
  - Flush counter and latched select are cleared.
- States: IDLE, FETCH, DECODE, EXEC, BRANCH, FLUSH, HALT. State register is the only sequential element besides instr_count, the flush counter and the latched select.
- Outputs are Moore decodes of state, except ir_load = (state==FETCH) & mem_ready.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH:
  - Waits for mem_ready=1, indefinitely if needed; busy stays 1 while waiting.
  - In the mem_ready=1 cycle: ir_load=1, then -> DECODE.
- DECODE (exactly 1 cycle; opcode and ovf_flag are sampled only here):
  - HALT_OPC -> HALT.
  - JMP_OPC -> latch select 10, -> BRANCH.
  - JNO_OPC with ovf_flag=0 -> latch select 01, -> BRANCH.
  - JNO_OPC with ovf_flag=1 -> EXEC as not-taken; reg_we is suppressed.
  - Any other opcode -> EXEC.
- EXEC (1 cycle):
  - pc_load=1, pc_sel=00.
  - reg_we=1 unless the instruction is a not-taken JNO.
  - -> FETCH.
- BRANCH (1 cycle): pc_load=1, pc_sel=latched select (01 or 10), reg_we=0. Load counter with FLUSH_CYC, -> FLUSH.
- FLUSH:
  - flush=1 for exactly FLUSH_CYC cycles.
  - pc_load=0, pc_sel=00.
  - -> FETCH.
- HALT: halted=1, busy=0, all strobes 0. Stays until rst; run is ignored.
- Outside loading cycles, pc_sel=00.
- instr_count:
  - Increments by 1 on each exit from DECODE to EXEC or BRANCH; a HALT instruction is not counted.
  - Saturates at 2^CNT_W-1 with no wrap.
- run deasserting after leaving IDLE has no effect.
- Changes on opcode or ovf_flag outside DECODE have no effect.
- Latency, with mem_ready already high:
  - ALU or not-taken JNO: 3 cycles (FETCH, DECODE, EXEC).
  - Taken branch: 3+FLUSH_CYC cycles.
  - Each mem_ready-low cycle in FETCH adds 1 cycle.

Test Plan:
- Reset then run=1 for 1 cycle, mem_ready=1, opcode=4'b0001 -> ir_load in cycle 1; EXEC in cycle 3 with reg_we=1, pc_load=1, pc_sel=00; instr_count=1.
- opcode=JNO, ovf_flag=0 -> BRANCH cycle with pc_sel=01, pc_load=1; flush=1 for 1 cycle; back in FETCH at cycle 5; instr_count increments.
- opcode=JNO, ovf_flag=1 -> EXEC with pc_sel=00, pc_load=1, reg_we=0; no flush.
- opcode=JMP with FLUSH_CYC=3 -> pc_sel=10 for 1 cycle; flush high exactly 3 cycles. ovf_flag toggled during FLUSH has no effect.
- mem_ready held low 5 cycles in FETCH -> ir_load=0 and busy=1 throughout; ir_load=1 only in the cycle mem_ready rises.
- HALT_OPC -> halted=1, busy=0, count unchanged, run pulses ignored. rst asserted mid-EXEC -> outputs 0 asynchronously and state is IDLE.
- With CNT_W=2, retire 5 ALU instructions -> instr_count saturates at 3.
